// File: rtl/click_event_ctrl_pkg.sv
// Shared widths, FIFO entry layout and command decode for the click event controller.
package click_event_ctrl_pkg;

    localparam int CEC_DEPTH = 8;
    localparam int CEC_AW    = 3;
    localparam int CEC_X_W   = 10;
    localparam int CEC_Y_W   = 9;
    localparam int CEC_ENT_W = 1 + CEC_X_W + CEC_Y_W;

    // Entry layout: {btn_id, x, y}
    localparam int ENT_Y_LSB = 0;
    localparam int ENT_X_LSB = CEC_Y_W;
    localparam int ENT_BID   = CEC_X_W + CEC_Y_W;

    localparam logic [31:0] CEC_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_CKO,
        CMD_CKX,
        CMD_CKY,
        CMD_BID,
        CMD_CLRP,
        CMD_NCK
    } cec_cmd_e;

    // Command strobes are one-hot; a stalled/flushed instruction decodes to no command.
    function automatic cec_cmd_e cec_decode(input logic ex_valid, input logic cko,
                                            input logic ckx, input logic cky,
                                            input logic bid, input logic clrp,
                                            input logic nck);
        cec_cmd_e cmd;
        cmd = CMD_NONE;
        if (ex_valid) begin
            if (cko)       cmd = CMD_CKO;
            else if (ckx)  cmd = CMD_CKX;
            else if (cky)  cmd = CMD_CKY;
            else if (bid)  cmd = CMD_BID;
            else if (clrp) cmd = CMD_CLRP;
            else if (nck)  cmd = CMD_NCK;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/click_event_ctrl_fifo.sv
// Click FIFO: storage, pointers and occupancy; flush beats push/pop, a pop frees a slot for a same-cycle push.
module click_fifo
    import click_event_ctrl_pkg::*;
#(
    parameter int DEPTH = CEC_DEPTH,
    parameter int AW    = CEC_AW,
    parameter int W     = CEC_ENT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_drop
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    assign w_push  = i_push & ~i_flush & (~w_full | w_pop);
    assign o_drop  = i_push & ~i_flush & w_full & ~w_pop;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/click_event_ctrl.sv
// Click event controller: button edge capture into the click FIFO and registered query results for the CPU.
module click_event_ctrl
    import click_event_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic [CEC_X_W-1:0] mouse_x,
    input  logic [CEC_Y_W-1:0] mouse_y,
    input  logic               ex_valid,
    input  logic               cko,
    input  logic               ckx,
    input  logic               cky,
    input  logic               bid,
    input  logic               clrp,
    input  logic               nck,
    output logic [31:0]        rdata,
    output logic               pending,
    output logic               overflow
);

    logic                 r_btn_l_q;
    logic                 r_btn_r_q;
    logic [31:0]          r_rdata;
    logic                 r_overflow;

    logic                 w_rise_l;
    logic                 w_rise_r;
    logic                 w_push;
    logic [CEC_ENT_W-1:0] w_entry;
    logic [CEC_ENT_W-1:0] w_head;
    logic                 w_empty;
    logic                 w_drop;
    logic [31:0]          w_rdata_nxt;
    cec_cmd_e             w_cmd;

    assign w_rise_l = btn_l & ~r_btn_l_q;
    assign w_rise_r = btn_r & ~r_btn_r_q;
    assign w_push   = w_rise_l | w_rise_r;
    // A simultaneous left+right press is recorded as a single left click.
    assign w_entry  = {~w_rise_l, mouse_x, mouse_y};
    assign w_cmd    = cec_decode(ex_valid, cko, ckx, cky, bid, clrp, nck);

    click_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_cmd == CMD_NCK),
        .i_flush (w_cmd == CMD_CLRP),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_rdata_nxt = r_rdata;
        case (w_cmd)
            CMD_CKO: w_rdata_nxt = {31'b0, ~w_empty};
            CMD_CKX: w_rdata_nxt = w_empty ? CEC_EMPTY
                                 : {{(32-CEC_X_W){1'b0}}, w_head[ENT_X_LSB +: CEC_X_W]};
            CMD_CKY: w_rdata_nxt = w_empty ? CEC_EMPTY
                                 : {{(32-CEC_Y_W){1'b0}}, w_head[ENT_Y_LSB +: CEC_Y_W]};
            CMD_BID: w_rdata_nxt = w_empty ? CEC_EMPTY : {31'b0, w_head[ENT_BID]};
            default: w_rdata_nxt = r_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_l_q  <= 1'b0;
            r_btn_r_q  <= 1'b0;
            r_rdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_btn_l_q <= btn_l;
            r_btn_r_q <= btn_r;
            r_rdata   <= w_rdata_nxt;
            if (w_cmd == CMD_CLRP)
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign rdata    = r_rdata;
    assign pending  = ~w_empty;
    assign overflow = r_overflow;

endmodule
